// File: rtl/serial_receiver_pkg.sv
// Shared definitions for the serial receiver slice: frame width, receiver
// state encoding and the Hamming(7,4) syndrome helper.
package serial_receiver_pkg;

    localparam int FRAME_WIDTH = 7;
    localparam int SYND_W      = 3;

    typedef enum logic {
        IDLE    = 1'b0,
        COLLECT = 1'b1
    } rx_state_t;

    // Syndrome of a 7-bit Hamming word; positions 1, 2 and 4 are parity bits.
    function automatic logic [SYND_W-1:0] hamming_syndrome(input logic [1:FRAME_WIDTH] w);
        logic s1;
        logic s2;
        logic s4;
        s1 = w[1] ^ w[3] ^ w[5] ^ w[7];
        s2 = w[2] ^ w[3] ^ w[6] ^ w[7];
        s4 = w[4] ^ w[5] ^ w[6] ^ w[7];
        return {s4, s2, s1};
    endfunction

endpackage

// File: rtl/serial_receiver_hamming7_corrector.sv
// Purely combinational Hamming(7,4) single-error corrector. A nonzero
// syndrome names the position (1..7) of the flipped bit.
module hamming7_corrector
    import serial_receiver_pkg::*;
(
    input  logic [1:FRAME_WIDTH] word,
    output logic [1:FRAME_WIDTH] fixed_word,
    output logic [SYND_W-1:0]    syndrome
);

    // Syndrome straight from the parity equations.
    always_comb begin
        syndrome = hamming_syndrome(word);
    end

    // Flip the bit the syndrome points at; syndrome 0 leaves the word as is.
    always_comb begin
        fixed_word = word;
        for (int i = 1; i <= FRAME_WIDTH; i++) begin
            if (syndrome == SYND_W'(i)) begin
                fixed_word[i] = ~word[i];
            end
        end
    end

endmodule

// File: rtl/serial_receiver.sv
// Serial-to-parallel frame receiver. Bits arrive on data_line, one per cycle
// in which strobe is high; the first bit lands in data_out[1].
// Optional macro HAMMING_CORRECT_EN: treat each 7-bit word as Hamming(7,4),
// correct a single-bit error before loading data_out and report
// syndrome/corrected (WIDTH must then be 7).
//
// Link protocol: strobe is a qualifier with no back-pressure. Every cycle
// with strobe = 1 carries exactly one frame bit; data_line is don't-care
// when strobe = 0. A frame is WIDTH consecutive strobed cycles; strobe
// dropping inside a frame aborts it (frame_err pulse). Outputs word_valid
// and frame_err are single-cycle pulses with no acknowledgement.
module serial_receiver
    import serial_receiver_pkg::*;
#(
    parameter int WIDTH = FRAME_WIDTH
)
(
    input  logic             clk,
    input  logic             rst,
    input  logic             data_line,
    input  logic             strobe,
    output logic [1:WIDTH]   data_out,
    output logic             word_valid,
    output logic             frame_err,
    output logic             busy
`ifdef HAMMING_CORRECT_EN
    ,
    output logic [SYND_W-1:0] syndrome,
    output logic             corrected
`endif
);

    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    rx_state_t         state;
    logic [CNT_W-1:0]  cnt;
    logic [1:WIDTH]    shift_buf;
    logic [1:WIDTH]    word_next;

    // Complete word as it stands once the final bit is merged in.
    always_comb begin
        word_next = {shift_buf[1:WIDTH-1], data_line};
    end

`ifdef HAMMING_CORRECT_EN
    logic [1:WIDTH]      fixed_word;
    logic [SYND_W-1:0]   synd_next;

    hamming7_corrector u_corrector (
        .word       (word_next),
        .fixed_word (fixed_word),
        .syndrome   (synd_next)
    );
`endif

    // Receiver FSM: collects strobed bits, loads data_out on the final bit
    // and raises the single-cycle status pulses.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            cnt        <= '0;
            shift_buf  <= '0;
            data_out   <= '0;
            word_valid <= 1'b0;
            frame_err  <= 1'b0;
            busy       <= 1'b0;
`ifdef HAMMING_CORRECT_EN
            syndrome   <= '0;
            corrected  <= 1'b0;
`endif
        end else begin
            word_valid <= 1'b0;
            frame_err  <= 1'b0;
            case (state)
                IDLE: begin
                    if (strobe) begin
                        shift_buf[1] <= data_line;
                        cnt          <= CNT_W'(1);
                        state        <= COLLECT;
                        busy         <= 1'b1;
                    end
                end
                COLLECT: begin
                    if (strobe) begin
                        for (int i = 1; i <= WIDTH; i++) begin
                            if (i == int'(cnt) + 1) begin
                                shift_buf[i] <= data_line;
                            end
                        end
                        if (cnt == LAST_CNT) begin
`ifdef HAMMING_CORRECT_EN
                            data_out  <= fixed_word;
                            syndrome  <= synd_next;
                            corrected <= |synd_next;
`else
                            data_out  <= word_next;
`endif
                            word_valid <= 1'b1;
                            cnt        <= '0;
                            state      <= IDLE;
                            busy       <= 1'b0;
                        end else begin
                            cnt <= cnt + CNT_W'(1);
                        end
                    end else begin
                        // Frame aborted: drop the partial word, keep data_out.
                        frame_err <= 1'b1;
                        cnt       <= '0;
                        state     <= IDLE;
                        busy      <= 1'b0;
                    end
                end
                default: begin
                    cnt   <= '0;
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_receiver.sv
// Self-checking bench for serial_receiver: directed frames from the test plan
// followed by random traffic, checked every cycle against a queue-based model.
module tb_serial_receiver;

    localparam int W = 7;

    logic         clk;
    logic         rst;
    logic         data_line;
    logic         strobe;
    logic [1:W]   data_out;
    logic         word_valid;
    logic         frame_err;
    logic         busy;
`ifdef HAMMING_CORRECT_EN
    logic [2:0]   syndrome;
    logic         corrected;
`endif

    int n_cmp  = 0;
    int n_fail = 0;

    // Model state: bits of the frame in progress, last published word.
    logic         frame_q[$];
    logic [W-1:0] exp_q[$];
    logic [1:W]   exp_dout;
    logic         exp_wv;
    logic         exp_fe;
    logic         exp_busy;
    logic [2:0]   exp_synd;
    logic         exp_corr;

    serial_receiver #(.WIDTH(W)) dut (
        .clk        (clk),
        .rst        (rst),
        .data_line  (data_line),
        .strobe     (strobe),
        .data_out   (data_out),
        .word_valid (word_valid),
        .frame_err  (frame_err),
        .busy       (busy)
`ifdef HAMMING_CORRECT_EN
        ,
        .syndrome   (syndrome),
        .corrected  (corrected)
`endif
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Hamming(7,4) correction computed from the parity equations.
    function automatic logic [1:W] ham_fix(input logic [1:W] w, output logic [2:0] s);
        logic [1:W] r;
        s[0] = w[1] ^ w[3] ^ w[5] ^ w[7];
        s[1] = w[2] ^ w[3] ^ w[6] ^ w[7];
        s[2] = w[4] ^ w[5] ^ w[6] ^ w[7];
        r = w;
        if (s != 3'd0) r[int'(s)] = ~w[int'(s)];
        return r;
    endfunction

    // Reference model: advance one clock with the inputs sampled at posedge.
    task automatic model_step(input logic s, input logic d, input logic r);
        logic [1:W] word;
        logic [2:0] sy;
        exp_wv = 1'b0;
        exp_fe = 1'b0;
        if (r) begin
            frame_q.delete();
            exp_dout = '0;
            exp_synd = '0;
            exp_corr = 1'b0;
        end else if (s) begin
            frame_q.push_back(d);
            if (frame_q.size() == W) begin
                for (int i = 0; i < W; i++) word[i + 1] = frame_q[i];
`ifdef HAMMING_CORRECT_EN
                word = ham_fix(word, sy);
                exp_synd = sy;
                exp_corr = (sy != 3'd0);
`else
                sy = '0;
`endif
                exp_dout = word;
                exp_wv = 1'b1;
                exp_q.push_back(word);
                frame_q.delete();
            end
        end else if (frame_q.size() > 0) begin
            exp_fe = 1'b1;
            frame_q.delete();
        end
        exp_busy = (frame_q.size() > 0);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Compare every output after the edge; word_valid pops the scoreboard.
    task automatic check_outputs();
        logic [W-1:0] w;
        chk("data_out", 32'(data_out), 32'(exp_dout));
        chk("word_valid", 32'(word_valid), 32'(exp_wv));
        chk("frame_err", 32'(frame_err), 32'(exp_fe));
        chk("busy", 32'(busy), 32'(exp_busy));
`ifdef HAMMING_CORRECT_EN
        chk("syndrome", 32'(syndrome), 32'(exp_synd));
        chk("corrected", 32'(corrected), 32'(exp_corr));
`endif
        if (word_valid === 1'b1) begin
            if (exp_q.size() > 0) begin
                w = exp_q.pop_front();
                chk("sb_word", 32'(data_out), 32'(w));
            end else begin
                chk("sb_unexpected_word", 32'(word_valid), 32'd0);
            end
        end
    endtask

    // Driver: one clock cycle with the given inputs.
    task automatic step(input logic s, input logic d, input logic r);
        @(negedge clk);
        strobe    = s;
        data_line = d;
        rst       = r;
        @(posedge clk);
        model_step(s, d, r);
        #1;
        check_outputs();
    endtask

    task automatic send_frame(input logic [1:W] w);
        for (int i = 1; i <= W; i++) step(1'b1, w[i], 1'b0);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'(i), 1'b0);
    endtask

    initial begin
        logic [1:W] w;
        int pulses;
        rst = 1'b1; strobe = 1'b0; data_line = 1'b0;
        exp_dout = '0; exp_wv = 1'b0; exp_fe = 1'b0; exp_busy = 1'b0;
        exp_synd = '0; exp_corr = 1'b0;

        // Reset state
        step(1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b1, 1'b1);

        // Single frame, then back-to-back frames with no gap
        send_frame(7'b1011001);
        idle(2);
        send_frame(7'b1011001);
        send_frame(7'b0100110);
        idle(1);

        // Aborted frame after 4 bits, then a clean frame
        for (int i = 0; i < 4; i++) step(1'b1, 1'(i), 1'b0);
        idle(2);
        send_frame(7'b1111111);
        idle(1);

        // Reset after bit 3, then an intact frame
        for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 1'b0);
        step(1'b0, 1'b0, 1'b1);
        send_frame(7'b0000001);
        idle(1);

        // Stray single strobe
        step(1'b1, 1'b1, 1'b0);
        idle(2);

`ifdef HAMMING_CORRECT_EN
        send_frame(7'b1010101);
        idle(1);
        send_frame(7'b1010001);
        idle(1);
`endif

        // Strobe low for 20 cycles with toggling data: nothing happens
        pulses = 0;
        for (int i = 0; i < 20; i++) begin
            step(1'b0, 1'(i), 1'b0);
            if (word_valid === 1'b1 || frame_err === 1'b1 || busy === 1'b1) pulses++;
        end
        chk("quiet_idle", 32'(pulses), 32'd0);

        // Random traffic: full frames, aborted frames, idle gaps, resets
        for (int n = 0; n < 60; n++) begin
            case ($urandom_range(0, 5))
                0, 1, 2: begin
                    w = W'($urandom);
                    send_frame(w);
                end
                3: begin
                    for (int i = 0; i < int'($urandom_range(1, W - 1)); i++)
                        step(1'b1, 1'($urandom), 1'b0);
                    step(1'b0, 1'($urandom), 1'b0);
                end
                4: begin
                    for (int i = 0; i < int'($urandom_range(1, 4)); i++)
                        step(1'b0, 1'($urandom), 1'b0);
                end
                default: begin
                    for (int i = 0; i < int'($urandom_range(0, W - 1)); i++)
                        step(1'b1, 1'($urandom), 1'b0);
                    step(1'($urandom), 1'($urandom), 1'b1);
                end
            endcase
        end
        idle(2);

        chk("sb_leftover", 32'(exp_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
